// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, the FIFO read port and the downstream stream.
// master: the reader's view; slave: the FIFO/consumer side.
interface fifo_reader_if #(
    parameter int unsigned WIDTH = 16
);
    logic             fifo_empty;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  fifo_empty, fifo_dout, fifo_valid, out_ready,
        output fifo_rd, out_data, out_valid
    );

    modport slave (
        output fifo_empty, fifo_dout, fifo_valid, out_ready,
        input  fifo_rd, out_data, out_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// Drains LEN words from a 1-cycle-latency FIFO into a 2-entry skid buffer feeding a valid/ready
// stream. Optional idle watchdog enabled by FIFO_READER_TIMEOUT_EN.
module fifo_reader #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [15:0]   len_i,
    fifo_reader_if.master bus_io,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   word_cnt_o,
    output logic          err_proto_o,
    output logic          err_timeout_o
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [15:0]      remain_q, remain_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic             err_proto_q;
    logic             ign_q;

    logic pop, push, rd, credit, to_hit;

    assign pop    = (occ_q != 2'd0) & bus_io.out_ready;
    assign push   = bus_io.fifo_valid & inflight_q;
    // A same-cycle pop frees a slot, so it is credited before issuing the next read.
    assign credit = ({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    assign rd     = (state_q == StRun) & ~bus_io.fifo_empty & (remain_q != 16'd0) & credit;

    assign bus_io.fifo_rd   = rd;
    assign bus_io.out_data  = mem_q[rd_ptr_q];
    assign bus_io.out_valid = (occ_q != 2'd0);
    assign busy_o           = (state_q != StIdle);
    assign done_o           = (state_q == StDone);
    assign word_cnt_o       = word_cnt_q;
    assign err_proto_o      = err_proto_q;

`ifdef FIFO_READER_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        err_to_q;

    assign to_hit        = (state_q == StRun) & ~rd & ((to_cnt_q + 16'd1) == 16'(TIMEOUT));
    assign to_cnt_d      = ((state_q != StRun) || rd) ? 16'd0 : to_cnt_q + 16'd1;
    assign err_timeout_o = err_to_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= 16'd0;
            err_to_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if (to_hit) err_to_q <= 1'b1;
        end
    end
`else
    assign to_hit        = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) occ_d = occ_q + 2'd1;
        else if (!push && pop) occ_d = occ_q - 2'd1;
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = rd ? remain_q - 16'd1 : remain_q;
        word_cnt_d = (pop && word_cnt_q != 16'hFFFF) ? word_cnt_q + 16'd1 : word_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    remain_d   = len_i;
                    word_cnt_d = 16'd0;
                    state_d    = (len_i == 16'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (to_hit) begin
                    remain_d = 16'd0;
                    state_d  = StDrain;
                end else if (remain_d == 16'd0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (occ_d == 2'd0 && !inflight_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            remain_q    <= 16'd0;
            word_cnt_q  <= 16'd0;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            err_proto_q <= 1'b0;
            ign_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            word_cnt_q <= word_cnt_d;
            occ_q      <= occ_d;
            inflight_q <= rd;
            ign_q      <= 1'b0;
            if (push) begin
                mem_q[wr_ptr_q] <= bus_io.fifo_dout;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            // A word left over from before reset may land in the first cycle; it is not an error.
            if (bus_io.fifo_valid && !inflight_q && !ign_q) err_proto_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader: behavioural FIFO model, expected-word scoreboard and a
// negedge monitor that checks order, read credit and transfer timing.
module tb_fifo_reader;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   len;
    logic          busy, done, err_proto, err_timeout;
    logic [15:0]   word_cnt;

    fifo_reader_if #(.WIDTH(W)) bus ();

    fifo_reader #(.WIDTH(W), .TIMEOUT(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .len_i        (len),
        .bus_io       (bus),
        .busy_o       (busy),
        .done_o       (done),
        .word_cnt_o   (word_cnt),
        .err_proto_o  (err_proto),
        .err_timeout_o(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // FIFO model: one-cycle read latency, EMPTY reflects reads of the previous cycle.
    logic [W-1:0] fq[$];
    logic [W-1:0] mdout;
    logic         mvalid;
    logic         stray;
    assign bus.fifo_valid = mvalid | stray;
    assign bus.fifo_dout  = mdout;

    always @(posedge clk) begin
        if (bus.fifo_rd && fq.size() > 0) begin
            mdout  <= fq.pop_front();
            mvalid <= 1'b1;
        end else begin
            mvalid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        bus.fifo_empty = (fq.size() == 0);
    end

    // Scoreboard and monitor
    logic [W-1:0] exp_q[$];
    int occ_m = 0;
    int inflight_m = 0;
    int first_rd, first_ov, last_pop, done_cyc, pops, rd_count;

    always @(negedge clk) begin
        int pop;
        pop = (bus.out_valid && bus.out_ready) ? 1 : 0;
        if (!rst && bus.fifo_rd) begin
            rd_count++;
            if (first_rd < 0) first_rd = cyc;
            chk("rd_while_empty", bus.fifo_empty, 0);
            chk("rd_credit", (occ_m + inflight_m - pop < 2) ? 1 : 0, 1);
        end
        if (!rst && bus.out_valid && first_ov < 0) first_ov = cyc;
        if (!rst && pop == 1) begin
            pops++;
            last_pop = cyc;
            if (exp_q.size() == 0) begin
                bad++;
                total++;
                $display("FAIL unexpected_word: got %0d expected none", bus.out_data);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
        if (!rst && done) done_cyc = cyc;
        if (rst) begin
            occ_m      = 0;
            inflight_m = 0;
        end else begin
            occ_m      = occ_m + ((bus.fifo_valid && inflight_m == 1) ? 1 : 0) - pop;
            inflight_m = bus.fifo_rd ? 1 : 0;
        end
    end

    logic rand_rdy = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    int t0;
    task automatic do_start(input logic [15:0] l);
        @(posedge clk);
        #1;
        start    = 1'b1;
        len      = l;
        t0       = cyc;
        first_rd = -1;
        first_ov = -1;
        last_pop = -1;
        done_cyc = -1;
        pops     = 0;
        rd_count = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cyc < 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", budget);
        end
    endtask

    task automatic load(input int n, input int nexp);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = W'($urandom);
            fq.push_back(w);
            if (i < nexp) exp_q.push_back(w);
        end
    endtask

    initial begin
        logic [W-1:0] seq[$];
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        stray = 1'b0;
        mvalid = 1'b0;
        mdout = '0;
        bus.out_ready = 1'b0;
        bus.fifo_empty = 1'b1;
        first_rd = -1; first_ov = -1; last_pop = -1; done_cyc = -1; pops = 0; rd_count = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", bus.fifo_rd, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_err_proto", err_proto, 0);
        chk("rst_err_timeout", err_timeout, 0);

        // Straight run of 10 words at full rate, with a stray START during RUN
        for (int i = 1; i <= 10; i++) begin
            fq.push_back(W'(i));
            exp_q.push_back(W'(i));
        end
        bus.out_ready = 1'b1;
        do_start(16'd10);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; len = 16'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        chk("t1_first_rd", first_rd, t0 + 1);
        chk("t1_first_ov", first_ov, t0 + 3);
        chk("t1_back_to_back", last_pop - first_ov, 9);
        chk("t1_done_cycle", done_cyc, last_pop + 1);
        chk("t1_pops", pops, 10);
        chk("t1_word_cnt", word_cnt, 10);
        chk("t1_exp_left", exp_q.size(), 0);
        @(negedge clk);
        chk("t1_idle", busy, 0);

        // Random backpressure, 7 words
        load(7, 7);
        rand_rdy = 1'b1;
        do_start(16'd7);
        wait_done(500);
        chk("t2_pops", pops, 7);
        chk("t2_word_cnt", word_cnt, 7);
        chk("t2_exp_left", exp_q.size(), 0);

        // Starvation: 3 words present, 4 more arrive later, LEN=5
        for (int i = 0; i < 7; i++) seq.push_back(W'($urandom));
        for (int i = 0; i < 3; i++) fq.push_back(seq[i]);
        for (int i = 0; i < 5; i++) exp_q.push_back(seq[i]);
        do_start(16'd5);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 3; i < 7; i++) fq.push_back(seq[i]);
        wait_done(500);
        chk("t3_pops", pops, 5);
        chk("t3_reads", rd_count, 5);
        chk("t3_word_cnt", word_cnt, 5);
        chk("t3_fifo_left", fq.size(), 2);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        fq.delete();

        // Zero-length transfer
        do_start(16'd0);
        wait_done(20);
        chk("t4_done_cycle", done_cyc, t0 + 1);
        chk("t4_reads", rd_count, 0);
        chk("t4_word_cnt", word_cnt, 0);

        // Stray FIFO_VALID, then reset in the middle of a transfer
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        chk("t5_err_proto_set", err_proto, 1);
        repeat (4) @(negedge clk);
        chk("t5_err_proto_sticky", err_proto, 1);
        load(6, 6);
        do_start(16'd6);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rd", bus.fifo_rd, 0);
        chk("t5_rst_out_valid", bus.out_valid, 0);
        chk("t5_rst_out_data", bus.out_data, 0);
        chk("t5_rst_word_cnt", word_cnt, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_err_proto", err_proto, 0);
        fq.delete();
        repeat (3) @(negedge clk);
        chk("t5_err_after_rst", err_proto, 0);

`ifdef FIFO_READER_TIMEOUT_EN
        load(2, 2);
        do_start(16'd4);
        wait_done(100);
        chk("t6_err_timeout", err_timeout, 1);
        chk("t6_word_cnt", word_cnt, 2);
        chk("t6_pops", pops, 2);
`else
        chk("t6_err_timeout_off", err_timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
